// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: register map and edge-mode constants shared by the PIO input capture block
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_pio_input_capture_if.sv
// nios_pio_input_capture_if: Avalon-MM slave register bus of the input PIO
interface nios_pio_input_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_pio_sync_edge.sv
// nios_pio_sync_edge: synchronizes in_port and produces per-bit edge pulses
module nios_pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // shift in_port through the synchronizer chain; prev holds the last stage one cycle late
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
            prev <= '0;
        end else begin
            sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign data  = sync[SYNC_STAGES-1];
    assign rise  = data & ~prev;
    assign fall  = ~data & prev;
    assign edges = (EDGE_TYPE == EDGE_FALLING) ? fall :
                   (EDGE_TYPE == EDGE_ANY)     ? (rise | fall) : rise;

endmodule

// File: rtl/nios_pio_input_capture.sv
// nios_pio_input_capture: Avalon-MM input PIO with sticky edge capture and masked level irq
module nios_pio_input_capture
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    nios_pio_input_capture_if.slave   bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_sel;
    logic             wr;
    logic             clear_wr;
    logic             unused_wd;

    nios_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .data    (data),
        .edges   (edges)
    );

    assign wr        = bus.chipselect && !bus.write_n;
    assign clear_wr  = wr && (bus.address == ADDR_EDGE_CAP);
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    // mask register write and sticky capture; a fresh edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            cap  <= '0;
        end else begin
            if (wr && bus.address == ADDR_IRQ_MASK) mask <= wd;
            cap <= edges | (cap & ~({WIDTH{clear_wr}} & wd));
        end
    end

    // zero-latency read mux; reserved address reads as zero
    always_comb begin
        rd_sel = (bus.address == ADDR_DATA)     ? data :
                 (bus.address == ADDR_IRQ_MASK) ? mask :
                 (bus.address == ADDR_EDGE_CAP) ? cap  : '0;
    end

    assign bus.readdata = 32'(rd_sel);
    assign irq          = |(cap & mask);

endmodule

// File: tb/tb_nios_pio_input_capture.sv
// tb_nios_pio_input_capture: table-driven and directed checks of the input capture PIO
module tb_nios_pio_input_capture;

    typedef struct {
        logic [15:0] pin;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          cyc;
        logic [1:0]  raddr;
        logic [31:0] rexp;
        logic        iexp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_port;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic        irq0, irq1, irq2;
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        vecs [25];

    nios_pio_input_capture_if b0 ();
    nios_pio_input_capture_if b1 ();
    nios_pio_input_capture_if b2 ();

    assign b0.address = addr; assign b0.chipselect = cs; assign b0.write_n = wn; assign b0.writedata = wd;
    assign b1.address = addr; assign b1.chipselect = cs; assign b1.write_n = wn; assign b1.writedata = wd;
    assign b2.address = addr; assign b2.chipselect = cs; assign b2.write_n = wn; assign b2.writedata = wd;

    nios_pio_input_capture #(.WIDTH(16), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
        .clk(clk), .reset(reset), .bus(b0), .in_port(in_port), .irq(irq0));
    nios_pio_input_capture #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset(reset), .bus(b1), .in_port(in_port), .irq(irq1));
    nios_pio_input_capture #(.WIDTH(16), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
        .clk(clk), .reset(reset), .bus(b2), .in_port(in_port), .irq(irq2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; addr = a; wd = d;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        in_port = v.pin;
        if (v.cyc > 0) begin
            cs = v.wr; wn = !v.wr; addr = v.waddr; wd = v.wdata;
            @(negedge clk);
            cs = 1'b0; wn = 1'b1;
            repeat (v.cyc - 1) @(negedge clk);
        end
        addr = v.raddr;
        #1;
        check($sformatf("vec%0d readdata", idx), b0.readdata, v.rexp);
        check($sformatf("vec%0d irq", idx), 32'(irq0), 32'(v.iexp));
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 1'b0, 2'd0, 32'h0,         1, 2'd0, 32'h0000, 1'b0};
        vecs[1]  = '{16'h0000, 1'b0, 2'd0, 32'h0,         1, 2'd2, 32'h0000, 1'b0};
        vecs[2]  = '{16'h0000, 1'b0, 2'd0, 32'h0,         1, 2'd3, 32'h0000, 1'b0};
        vecs[3]  = '{16'h00A5, 1'b0, 2'd0, 32'h0,         1, 2'd0, 32'h0000, 1'b0};
        vecs[4]  = '{16'h00A5, 1'b0, 2'd0, 32'h0,         1, 2'd0, 32'h00A5, 1'b0};
        vecs[5]  = '{16'h00A5, 1'b0, 2'd0, 32'h0,         0, 2'd3, 32'h0000, 1'b0};
        vecs[6]  = '{16'h00A5, 1'b0, 2'd0, 32'h0,         1, 2'd3, 32'h00A5, 1'b0};
        vecs[7]  = '{16'h00A5, 1'b1, 2'd3, 32'h0000FFFF,  1, 2'd3, 32'h0000, 1'b0};
        vecs[8]  = '{16'h00A5, 1'b1, 2'd2, 32'h00000001,  1, 2'd2, 32'h0001, 1'b0};
        vecs[9]  = '{16'h00A4, 1'b0, 2'd0, 32'h0,         3, 2'd3, 32'h0000, 1'b0};
        vecs[10] = '{16'h00A5, 1'b0, 2'd0, 32'h0,         2, 2'd3, 32'h0000, 1'b0};
        vecs[11] = '{16'h00A5, 1'b0, 2'd0, 32'h0,         1, 2'd3, 32'h0001, 1'b1};
        vecs[12] = '{16'h00A5, 1'b1, 2'd3, 32'h00000001,  1, 2'd3, 32'h0000, 1'b0};
        vecs[13] = '{16'h00A7, 1'b0, 2'd0, 32'h0,         3, 2'd3, 32'h0002, 1'b0};
        vecs[14] = '{16'h00A7, 1'b1, 2'd3, 32'h00000000,  1, 2'd3, 32'h0002, 1'b0};
        vecs[15] = '{16'h00A7, 1'b1, 2'd0, 32'h0000FFFF,  1, 2'd0, 32'h00A7, 1'b0};
        vecs[16] = '{16'h00A7, 1'b1, 2'd1, 32'h0000FFFF,  1, 2'd1, 32'h0000, 1'b0};
        vecs[17] = '{16'h00A7, 1'b1, 2'd2, 32'hFFFF0003,  1, 2'd2, 32'h0003, 1'b1};
        vecs[18] = '{16'h00A7, 1'b1, 2'd2, 32'h00000000,  1, 2'd2, 32'h0000, 1'b0};
        vecs[19] = '{16'h00A3, 1'b0, 2'd0, 32'h0,         3, 2'd3, 32'h0002, 1'b0};
        vecs[20] = '{16'h00A7, 1'b0, 2'd0, 32'h0,         3, 2'd3, 32'h0006, 1'b0};
        vecs[21] = '{16'h00A3, 1'b0, 2'd0, 32'h0,         3, 2'd3, 32'h0006, 1'b0};
        vecs[22] = '{16'h00A7, 1'b0, 2'd0, 32'h0,         2, 2'd3, 32'h0006, 1'b0};
        vecs[23] = '{16'h00A7, 1'b1, 2'd3, 32'h00000004,  1, 2'd3, 32'h0006, 1'b0};
        vecs[24] = '{16'h00A7, 1'b1, 2'd3, 32'h00000004,  1, 2'd3, 32'h0002, 1'b0};

        reset = 1'b1; in_port = '0; addr = '0; cs = 1'b0; wn = 1'b1; wd = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) apply(i, vecs[i]);

        // both-edge and falling-edge variants on bit 15
        wr(2'd3, 32'hFFFFFFFF);
        in_port = 16'h80A7;
        repeat (3) @(negedge clk);
        addr = 2'd3; #1;
        check("any rise cap", b1.readdata, 32'h8000);
        check("fall rise cap", b2.readdata, 32'h0000);
        wr(2'd3, 32'hFFFFFFFF);
        addr = 2'd3; #1;
        check("any cleared", b1.readdata, 32'h0000);
        in_port = 16'h00A7;
        repeat (3) @(negedge clk);
        addr = 2'd3; #1;
        check("any fall cap", b1.readdata, 32'h8000);
        check("fall fall cap", b2.readdata, 32'h8000);

        // reset mid-operation with captured bits and pending irq
        in_port = 16'h0000;
        repeat (3) @(negedge clk);
        wr(2'd3, 32'hFFFFFFFF);
        in_port = 16'h00FF;
        repeat (3) @(negedge clk);
        wr(2'd2, 32'h000000FF);
        addr = 2'd3; #1;
        check("pre-reset cap", b0.readdata, 32'h00FF);
        check("pre-reset irq", 32'(irq0), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        addr = 2'd3; #1;
        check("post-reset cap", b0.readdata, 32'h0000);
        check("post-reset irq", 32'(irq0), 32'h0);
        addr = 2'd2; #1;
        check("post-reset mask", b0.readdata, 32'h0000);
        addr = 2'd0; #1;
        check("post-reset data", b0.readdata, 32'h0000);
        wr(2'd1, 32'h0000FFFF);
        addr = 2'd1; #1;
        check("addr1 read", b0.readdata, 32'h0000);
        @(negedge clk);
        addr = 2'd3; #1;
        check("held-high cap early", b0.readdata, 32'h0000);
        @(negedge clk);
        addr = 2'd3; #1;
        check("held-high cap", b0.readdata, 32'h00FF);
        check("held-high irq", 32'(irq0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_pio_input_capture.md
Name: nios_pio_input_capture

Overview:
- Avalon-MM slave input PIO, the read-side counterpart of the existing output PIO that drives LEDs/hex.
- Samples an external WIDTH-bit input bus (switches/keys) through a synchronizer and detects per-bit edges into a sticky edge-capture register.
- Raises a level IRQ to the Nios II when a captured edge is unmasked.
- Sits on the system interconnect next to the output PIOs.

Parameters:
- WIDTH, 16, width of in_port and of every internal register (1..32)
- EDGE_TYPE, 0, edge capture mode: 0 = rising, 1 = falling, 2 = any
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>= 2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- address  input  2  word address of register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data; bits [WIDTH-1:0] used
- in_port  input  WIDTH  asynchronous external inputs
- readdata  output  32  read data, zero-extended above WIDTH
- irq  output  1  level interrupt, active-high

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. All state updates occur on the rising edge of clk. While reset = 1 on an edge, every register clears.
- Register map:
  - 0 DATA: read-only; synchronized in_port.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read; write-1-to-clear.
  - 1: reads 0; writes are ignored.
- Write qualifier: chipselect && !write_n. Read path is combinational (read latency 0). readdata = selected register zero-extended; unselected addresses return 0.
- Synchronizer: SYNC_STAGES-deep shift chain sync[] on in_port, plus prev = last stage delayed one cycle.
  - DATA = last sync stage.
  - Latency from an in_port change to DATA: SYNC_STAGES cycles.
- Edge detect, per bit:
  - rise = sync & ~prev
  - fall = ~sync & prev
  - edge = rise, fall, or rise|fall per EDGE_TYPE
  - An edge becomes visible in EDGE_CAPTURE SYNC_STAGES+1 cycles after the in_port change.
- Capture, per bit i:
  - next = edge[i] ? 1 : (clear_wr && writedata[i]) ? 0 : cap[i]
  - A new edge in the same cycle as a clear wins; the bit stays 1.
  - Writing 0 to a bit leaves it unchanged.
- IRQ: irq = |(cap & mask), combinational from registers.
  - Asserts the cycle after the capturing edge, if masked in.
  - Deasserts the cycle after a clear or mask write removes the last active bit.
- Reset values: sync chain, prev, mask, cap = 0; hence readdata = 0 and irq = 0.
  - Because prev resets to 0, an input held high through reset produces a rising edge SYNC_STAGES+1 cycles after reset release (rising/any modes). This is intended: software clears EDGE_CAPTURE at init.
- Reset mid-operation (reset asserted with captured bits and pending irq): cap and mask clear on that edge; irq drops the same cycle.
- Writes to DATA are ignored. writedata bits at or above WIDTH are ignored.

Decomposition:
- Shared package nios_pio_pkg holds:
  - register address constants ADDR_DATA = 0, ADDR_IRQ_MASK = 2, ADDR_EDGE_CAP = 3
  - edge mode constants EDGE_RISING / EDGE_FALLING / EDGE_ANY
- One sub-module: nios_pio_sync_edge (parameterized WIDTH, SYNC_STAGES, EDGE_TYPE). Outputs the synchronized data and the per-bit edge vector.
- The top level keeps the register file, capture logic, read mux and irq.

Test Plan:
1. Reset, then read addr 0/2/3 with in_port = 0 -> readdata 0x0 on all; irq = 0.
2. in_port 0x0000 -> 0x00A5 (EDGE_TYPE = 0) -> DATA reads 0x00A5 after 2 cycles; EDGE_CAPTURE reads 0x00A5 after 3 cycles; irq stays 0 (mask = 0).
3. Write mask 0x0001, then edge on bit 0 -> irq = 1; write 0x0001 to addr 3 -> irq = 0 next cycle; then write 0x0000 to addr 3 on another set bit -> no change.
4. Simultaneous clear write of bit 2 and new rising edge on bit 2 in the same cycle -> cap[2] remains 1.
5. EDGE_TYPE = 2, toggle bit 15 high then low with clears between -> captured on both transitions; with EDGE_TYPE = 1 only the high-to-low transition captures.
6. Assert reset for 1 cycle while cap = 0x00FF, mask = 0x00FF, irq = 1 -> next cycle cap = 0, mask = 0, irq = 0. Write to addr 1 with 0xFFFF -> reads 0.
